// File: rtl/signed_mult_arbiter.sv
// rtl/signed_mult_arbiter.sv - two-port arbiter sharing one signed multiplier, 2-entry response FIFO
// Optional MULT_ARB_RR_EN selects round-robin arbitration; the default build uses fixed priority (port 0 first).
module signed_mult_arbiter #(
    parameter int W  = 4,
    parameter int PW = 2 * W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0_valid,
    input  logic [W-1:0]  req0_a,
    input  logic [W-1:0]  req0_b,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic [W-1:0]  req1_a,
    input  logic [W-1:0]  req1_b,
    output logic          req1_ready,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [PW-1:0] rsp_prod,
    output logic          rsp_id,
    output logic          busy
);

    logic [1:0]    count_q, count_d;
    logic          wr_ptr_q, rd_ptr_q;
    logic [PW-1:0] prod_q [2];
    logic [1:0]    id_q;

    logic          pop, push, space, grant;
    logic [W-1:0]  a_sel, b_sel;
    logic [PW-1:0] a_ext, b_ext, prod;

`ifdef MULT_ARB_RR_EN
    logic last_q;
    // Pointer only breaks ties; a lone valid port always wins.
    assign grant = req0_valid ? (req1_valid & ~last_q) : req1_valid;
`else
    assign grant = ~req0_valid & req1_valid;
`endif

    assign pop        = rsp_valid & rsp_ready;
    assign space      = (count_q < 2'd2) | pop;
    assign req0_ready = rst_n & space & ~grant;
    assign req1_ready = rst_n & space & grant;
    assign push       = grant ? (req1_valid & req1_ready) : (req0_valid & req0_ready);

    assign a_sel = grant ? req1_a : req0_a;
    assign b_sel = grant ? req1_b : req0_b;
    assign a_ext = {{(PW-W){a_sel[W-1]}}, a_sel};
    assign b_ext = {{(PW-W){b_sel[W-1]}}, b_sel};
    assign prod  = a_ext * b_ext;

    always_comb begin
        count_d = count_q;
        if (push && !pop)
            count_d = count_q + 2'd1;
        else if (!push && pop)
            count_d = count_q - 2'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q   <= 2'd0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            prod_q[0] <= '0;
            prod_q[1] <= '0;
            id_q      <= 2'b00;
`ifdef MULT_ARB_RR_EN
            last_q    <= 1'b1;
`endif
        end else begin
            count_q <= count_d;
            if (push) begin
                prod_q[wr_ptr_q] <= prod;
                id_q[wr_ptr_q]   <= grant;
                wr_ptr_q         <= ~wr_ptr_q;
`ifdef MULT_ARB_RR_EN
                last_q           <= grant;
`endif
            end
            if (pop)
                rd_ptr_q <= ~rd_ptr_q;
        end
    end

    assign rsp_valid = (count_q != 2'd0);
    assign busy      = (count_q != 2'd0);
    assign rsp_prod  = prod_q[rd_ptr_q];
    assign rsp_id    = id_q[rd_ptr_q];

endmodule

// File: tb/tb_signed_mult_arbiter.sv
// tb/tb_signed_mult_arbiter.sv - directed self-checking bench for signed_mult_arbiter
module tb_signed_mult_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0_valid, req0_ready, req1_valid, req1_ready;
    logic [3:0] req0_a, req0_b, req1_a, req1_b;
    logic       rsp_valid, rsp_ready, rsp_id, busy;
    logic [7:0] rsp_prod;

    int total = 0;
    int bad   = 0;

    signed_mult_arbiter #(.W(4), .PW(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_prod(rsp_prod), .rsp_id(rsp_id),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 4'd1; req0_b = 4'd1;
        req1_valid = 1'b1; req1_a = 4'd3; req1_b = 4'd3;
        tick(); tick();
        total++;
        if ({req0_ready, req1_ready, rsp_valid, busy} !== 4'b0000) begin
            bad++; $display("FAIL reset_flags: got %b expected 0000", {req0_ready, req1_ready, rsp_valid, busy});
        end
        total++;
        if ({rsp_id, rsp_prod} !== 9'h000) begin
            bad++; $display("FAIL reset_rsp: got id=%0d prod=%h expected 0/00", rsp_id, rsp_prod);
        end
        rst_n = 1'b1;
        #1;
        total++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            bad++; $display("FAIL reset_first_grant: got %b expected 10", {req0_ready, req1_ready});
        end
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        total++;
        if ({rsp_valid, rsp_id, rsp_prod} !== {1'b1, 1'b0, 8'h01}) begin
            bad++; $display("FAIL reset_first_rsp: got v=%b id=%0d prod=%h expected 1/0/01", rsp_valid, rsp_id, rsp_prod);
        end
        tick();
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL reset_drain: got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_single();
        req0_valid = 1'b1; req0_a = 4'b1101; req0_b = 4'b0010; rsp_ready = 1'b1;
        #1;
        total++;
        if (req0_ready !== 1'b1) begin
            bad++; $display("FAIL single_ready: got %b expected 1", req0_ready);
        end
        tick();
        req0_valid = 1'b0;
        total++;
        if ({rsp_valid, rsp_id, rsp_prod} !== {1'b1, 1'b0, 8'hFA}) begin
            bad++; $display("FAIL single_prod: got v=%b id=%0d prod=%h expected 1/0/fa", rsp_valid, rsp_id, rsp_prod);
        end
        tick();
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL single_drain: got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_corner();
        logic [3:0] av [4] = '{4'd7, 4'b1000, 4'b1011, 4'd4};
        logic [3:0] bv [4] = '{4'b1000, 4'b1000, 4'b1010, 4'd3};
        logic [7:0] pv [4] = '{8'hC8, 8'h40, 8'h1E, 8'h0C};
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req1_valid = 1'b1; req1_a = av[i]; req1_b = bv[i];
            tick();
            total++;
            if ({rsp_valid, rsp_id, rsp_prod} !== {1'b1, 1'b1, pv[i]}) begin
                bad++; $display("FAIL corner_%0d: got v=%b id=%0d prod=%h expected 1/1/%h", i, rsp_valid, rsp_id, rsp_prod, pv[i]);
            end
        end
        req1_valid = 1'b0;
        tick();
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL corner_drain: got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_back_to_back();
        logic       exp_id;
        logic [7:0] exp_prod;
        req0_valid = 1'b1; req0_a = 4'd1; req0_b = 4'd2;
        req1_valid = 1'b1; req1_a = 4'd3; req1_b = 4'd3;
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
`ifdef MULT_ARB_RR_EN
            exp_id = i[0];
`else
            exp_id = 1'b0;
            #1;
            total++;
            if (req1_ready !== 1'b0) begin
                bad++; $display("FAIL fixed_req1_ready_%0d: got %b expected 0", i, req1_ready);
            end
`endif
            exp_prod = exp_id ? 8'h09 : 8'h02;
            tick();
            total++;
            if ({rsp_valid, rsp_id, rsp_prod} !== {1'b1, exp_id, exp_prod}) begin
                bad++; $display("FAIL b2b_%0d: got v=%b id=%0d prod=%h expected 1/%0d/%h", i, rsp_valid, rsp_id, rsp_prod, exp_id, exp_prod);
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL b2b_drain: got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_backpressure();
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 4'b1101; req0_b = 4'd2;
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_a = 4'd7; req1_b = 4'b1000;
        tick();
        req0_valid = 1'b1;
        #1;
        total++;
        if ({req0_ready, req1_ready, busy, rsp_valid} !== 4'b0011) begin
            bad++; $display("FAIL bp_full: got rdy/busy/v=%b expected 0011", {req0_ready, req1_ready, busy, rsp_valid});
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if ({rsp_id, rsp_prod} !== {1'b0, 8'hFA}) begin
                bad++; $display("FAIL bp_hold_%0d: got id=%0d prod=%h expected 0/fa", i, rsp_id, rsp_prod);
            end
        end
        rsp_ready = 1'b1;
        #1;
        total++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            bad++; $display("FAIL bp_pop_ready: got %b expected 10", {req0_ready, req1_ready});
        end
        tick();
        rsp_ready = 1'b0;
        #1;
        total++;
        if ({req0_ready, req1_ready, busy, rsp_id, rsp_prod} !== {4'b0011, 8'hC8}) begin
            bad++; $display("FAIL bp_still_full: got rdy=%b busy=%b id=%0d prod=%h expected 00/1/1/c8", {req0_ready, req1_ready}, busy, rsp_id, rsp_prod);
        end
    endtask

    task automatic test_reset_full();
        rst_n = 1'b0;
        tick();
        total++;
        if ({rsp_valid, busy, req0_ready, req1_ready, rsp_prod} !== 12'h000) begin
            bad++; $display("FAIL rst_full: got v=%b busy=%b rdy=%b prod=%h expected all 0", rsp_valid, busy, {req0_ready, req1_ready}, rsp_prod);
        end
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if ({rsp_valid, busy} !== 2'b00) begin
                bad++; $display("FAIL rst_stale_%0d: got v=%b busy=%b expected 0/0", i, rsp_valid, busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_corner();
        test_back_to_back();
        test_backpressure();
        test_reset_full();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/signed_mult_arbiter.md
# signed_mult_arbiter

Shares one combinational signed multiplier between two requesters. Each requester presents a pair of two's-complement operands with a valid/ready handshake. The block arbitrates, computes the full-width signed product, and queues the product plus the requester id in a 2-entry response FIFO. It sits between the requester logic and the shared signed multiplier datapath and is the only block that drives the multiplier's operands.

## Interface
Parameters:
- W, 4, operand width in bits, two's complement, W ≥ 2.
- PW, 2*W, product width. Fixed at 2*W so that (−2^(W−1))·(−2^(W−1)) is representable.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- req0_valid  in  1  requester 0 has an operand pair.
- req0_a  in  W  requester 0 multiplicand, signed.
- req0_b  in  W  requester 0 multiplier, signed.
- req0_ready  out  1  requester 0 transfer accepted this cycle.
- req1_valid, req1_a, req1_b, req1_ready: same as requester 0, for requester 1.
- rsp_valid  out  1  FIFO head holds a result.
- rsp_ready  in  1  consumer accepts the head this cycle.
- rsp_prod  out  PW  signed product at the FIFO head.
- rsp_id  out  1  requester id of the head (0 or 1).
- busy  out  1  high when the FIFO is non-empty (count != 0).

## Operation
- Transfer rules:
  - Request transfer: reqN_valid && reqN_ready on a clock edge.
  - Response transfer: rsp_valid && rsp_ready on a clock edge.
- Space:
  - pop = rsp_valid && rsp_ready.
  - space = (count < 2) || pop.
  - At most one grant per cycle.
- Grant:
  - reqN_ready = space && grant==N.
  - reqN_ready is combinational from the valids, rsp_ready, count and the pointer.
  - reqN_ready never depends on reqN_valid of the same port in a way that forms a loop: the grant decision uses both valids, and the ready of the non-granted port is 0.
- Arbitration, round-robin mode (see Configuration):
  - A 1-bit pointer last holds the id of the most recent accepted request. Reset value of last is 1, so port 0 wins the first contention.
  - Both valid: grant = ~last.
  - Exactly one valid: grant = that port.
  - last updates only on an accepted transfer.
- Datapath:
  - Selected operands go to the shared multiplier.
  - Product = sign-extend(a) × sign-extend(b), truncated to PW bits. No overflow is possible.
  - Examples: −3×2 = 8'hFA; 7×−8 = 8'hC8; −8×−8 = 8'h40.
- Response FIFO:
  - 2 entries of {id, prod}.
  - Write pointer and read pointer are 1 bit each; count is 0..2.
  - Simultaneous push and pop: count unchanged and both pointers advance. This is legal when full, because space includes pop.
  - Pop when empty cannot occur, because rsp_valid = 0.
- rsp_prod and rsp_id:
  - Driven from the head entry.
  - Must hold stable while rsp_valid && !rsp_ready.
- No request is dropped or reordered. Results leave the FIFO in acceptance order.

## Timing
- Reset (rst_n = 0 at an edge):
  - count = 0, pointers = 0, last = 1.
  - rsp_valid = 0, busy = 0, rsp_prod = 0, rsp_id = 0.
  - req0_ready = req1_ready = 0 while rst_n = 0.
  - FIFO entries are cleared to 0.
- Reset mid-operation discards all queued results. The first request is accepted on the first edge with rst_n = 1.
- Latency: a request accepted at edge N appears on rsp_* with rsp_valid = 1 in the cycle after edge N, provided no older entries are queued.
- Throughput: one accept per cycle while the consumer holds rsp_ready = 1.
  - Alternating grants when both ports are valid: 0,1,0,1…
- Backpressure:
  - With rsp_ready = 0, two accepts fill the FIFO.
  - Both readies are then 0 until a pop.
  - In a pop cycle, one new request can be accepted.

## Configuration
- MULT_ARB_RR_EN defined: round-robin arbitration as specified, with the last pointer.
- MULT_ARB_RR_EN undefined: fixed priority.
  - Port 0 always wins when both ports are valid; the last pointer is not implemented.
  - Port 1 is granted only when req0_valid = 0.
- Everything else is identical in both builds.

## Test plan
- Reset with rst_n = 0 for 2 cycles, both valids high:
  - All readies 0, rsp_valid = 0, busy = 0.
  - After release, the first grant goes to port 0.
- Single requester, port 0: a = 4'b1101 (−3), b = 4'b0010, rsp_ready = 1.
  - One cycle later: rsp_valid = 1, rsp_prod = 8'hFA, rsp_id = 0.
- Corner operands on port 1: (7,−8), (−8,−8), (−5,−6), (4,3).
  - Required products in order: 8'hC8, 8'h40, 8'h1E, 8'h0C; all with id = 1.
- Both ports valid continuously, rsp_ready = 1:
  - With MULT_ARB_RR_EN: ids alternate 0,1,0,1.
  - Without MULT_ARB_RR_EN: ids are all 0 and req1_ready stays 0.
- Backpressure: rsp_ready = 0, two accepts.
  - count = 2 and both readies = 0.
  - rsp_prod stays stable across 5 cycles.
  - Raising rsp_ready for one cycle gives a simultaneous pop and accept; count stays 2.
- Reset asserted with count = 2:
  - Next cycle: rsp_valid = 0, busy = 0.
  - No stale results appear after release.
